// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with the ID/EX pipeline register.
//
// Decodes the 16-bit instruction held in IF/ID, reads the 16-entry register
// file (optionally bypassing the same-cycle write-back), resolves branches in
// ID and detects load-use, branch-operand and branch-flag hazards. Decoded
// control and operands are registered for EX.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_instr/if_pc  IF/ID contents (if_pc is PC+2 of if_instr)
//   flag                     {Z,V,N} for the instruction in ID
//   wb_we/wb_rd/wb_data      register file write port
//   mem_regwrite/mem_rd      destination of the instruction in MEM
//   ext_stall                downstream freeze, holds ID/EX
//   id_stall                 hold PC and IF/ID (combinational)
//   br_taken/br_target       redirect request and target (combinational)
//   ex_*                     registered ID/EX contents
module id_stage_pipe #(
  parameter int DATA_W    = 16,
  parameter bit WB_BYPASS = 1'b1,
  parameter bit R0_ZERO   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [2:0]        flag,
  input  logic              wb_we,
  input  logic [3:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_regwrite,
  input  logic [3:0]        mem_rd,
  input  logic              ext_stall,
  output logic              id_stall,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic              ex_setflags,
  output logic              ex_halt,
  output logic [3:0]        ex_aluop,
  output logic [3:0]        ex_rs,
  output logic [3:0]        ex_rt,
  output logic [3:0]        ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              alusrc;
    logic              setflags;
    logic              halt;
    logic [3:0]        aluop;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [3:0]        rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
  } idEx_t;

  idEx_t             idEx_q, idEx_d, decCtl;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] regFile_q [16];
  logic [DATA_W-1:0] rsData, rtData;
  logic [3:0]        op;
  logic              usesRs, usesRt, usePc, isB, isBr, condOk, hazard;
  logic              zFlag, vFlag, nFlag;

  assign op = if_instr[15:12];
  assign {zFlag, vFlag, nFlag} = flag;

  // Instruction decode into the control half of an ID/EX entry; operands are
  // filled in later once the register reads are known. PCS is sent to EX as
  // if_pc plus a zero immediate so the ALU passes the link value through.
  always_comb begin
    decCtl       = '0;
    decCtl.aluop = op;
    decCtl.rd    = if_instr[11:8];
    decCtl.rs    = if_instr[7:4];
    decCtl.rt    = if_instr[3:0];
    usesRs       = 1'b0;
    usesRt       = 1'b0;
    usePc        = 1'b0;
    isB          = 1'b0;
    isBr         = 1'b0;
    case (op)
      4'h0, 4'h1, 4'h2: begin
        decCtl.regwrite = 1'b1;
        decCtl.setflags = 1'b1;
        usesRs          = 1'b1;
        usesRt          = 1'b1;
      end
      4'h3, 4'h7: begin
        decCtl.regwrite = 1'b1;
        usesRs          = 1'b1;
        usesRt          = 1'b1;
      end
      4'h4, 4'h5, 4'h6: begin
        decCtl.regwrite = 1'b1;
        decCtl.setflags = 1'b1;
        decCtl.alusrc   = 1'b1;
        decCtl.imm      = {{(DATA_W-4){if_instr[3]}}, if_instr[3:0]};
        usesRs          = 1'b1;
      end
      4'h8: begin
        decCtl.aluop    = 4'h0;
        decCtl.alusrc   = 1'b1;
        decCtl.imm      = {{(DATA_W-4){if_instr[3]}}, if_instr[3:0]};
        decCtl.regwrite = 1'b1;
        decCtl.memread  = 1'b1;
        decCtl.memtoreg = 1'b1;
        usesRs          = 1'b1;
      end
      4'h9: begin
        decCtl.aluop    = 4'h0;
        decCtl.alusrc   = 1'b1;
        decCtl.imm      = {{(DATA_W-4){if_instr[3]}}, if_instr[3:0]};
        decCtl.memwrite = 1'b1;
        decCtl.rt       = if_instr[11:8];
        usesRs          = 1'b1;
        usesRt          = 1'b1;
      end
      4'hA, 4'hB: begin
        decCtl.rs       = if_instr[11:8];
        decCtl.regwrite = 1'b1;
        decCtl.alusrc   = 1'b1;
        decCtl.imm      = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
        usesRs          = 1'b1;
      end
      4'hC: isB = 1'b1;
      4'hD: begin
        isBr   = 1'b1;
        usesRs = 1'b1;
      end
      4'hE: begin
        decCtl.aluop    = 4'h0;
        decCtl.regwrite = 1'b1;
        decCtl.alusrc   = 1'b1;
        usePc           = 1'b1;
      end
      default: decCtl.halt = 1'b1;
    endcase
  end

  // Register reads; r0 forcing takes priority over the write-back bypass.
  always_comb begin
    rsData = regFile_q[decCtl.rs];
    if (WB_BYPASS && wb_we && (wb_rd == decCtl.rs)) rsData = wb_data;
    if (R0_ZERO && (decCtl.rs == 4'd0)) rsData = '0;
    rtData = regFile_q[decCtl.rt];
    if (WB_BYPASS && wb_we && (wb_rd == decCtl.rt)) rtData = wb_data;
    if (R0_ZERO && (decCtl.rt == 4'd0)) rtData = '0;
  end

  // Branch condition selected by the 3-bit code in [11:9].
  always_comb begin
    case (if_instr[11:9])
      3'b000:  condOk = !zFlag;
      3'b001:  condOk = zFlag;
      3'b010:  condOk = !zFlag && !nFlag;
      3'b011:  condOk = nFlag;
      3'b100:  condOk = zFlag || !nFlag;
      3'b101:  condOk = zFlag || nFlag;
      3'b110:  condOk = vFlag;
      default: condOk = 1'b1;
    endcase
  end

  // Hazards: a load in EX feeding this instruction, a BR whose target
  // register is still being produced in EX or MEM, and a conditional branch
  // whose flags are still being produced by the instruction in EX.
  always_comb begin
    hazard = 1'b0;
    if (idEx_q.valid && idEx_q.memread && (idEx_q.rd != 4'd0) &&
        ((usesRs && (idEx_q.rd == decCtl.rs)) || (usesRt && (idEx_q.rd == decCtl.rt))))
      hazard = 1'b1;
    if (isBr && ((idEx_q.valid && idEx_q.regwrite && (idEx_q.rd == decCtl.rs)) ||
                 (mem_regwrite && (mem_rd == decCtl.rs))))
      hazard = 1'b1;
    if ((isB || isBr) && (if_instr[11:9] != 3'b111) && idEx_q.valid && idEx_q.setflags)
      hazard = 1'b1;
  end

  assign id_stall  = hazard || ext_stall || halted_q;
  assign br_taken  = if_valid && (isB || isBr) && condOk && !id_stall;
  assign br_target = isBr ? rsData
                          : if_pc + {{(DATA_W-10){if_instr[8]}}, if_instr[8:0], 1'b0};

  // ID/EX next state: a freeze holds everything, a hazard, empty slot or
  // halted core inserts an all-zero bubble, otherwise the decoded entry loads.
  always_comb begin
    idEx_d   = idEx_q;
    halted_d = halted_q;
    if (!ext_stall) begin
      if (hazard || !if_valid || halted_q) begin
        idEx_d = '0;
      end else begin
        idEx_d       = decCtl;
        idEx_d.valid = 1'b1;
        idEx_d.a     = usePc ? if_pc : rsData;
        idEx_d.b     = rtData;
        if (decCtl.halt) halted_d = 1'b1;
      end
    end
  end

  // Pipeline register and sticky halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      idEx_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      idEx_q   <= idEx_d;
      halted_q <= halted_d;
    end
  end

  // Register file; writes to r0 are dropped when r0 is hardwired to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regFile_q[i] <= '0;
    end else if (wb_we && !(R0_ZERO && (wb_rd == 4'd0))) begin
      regFile_q[wb_rd] <= wb_data;
    end
  end

  assign ex_valid    = idEx_q.valid;
  assign ex_regwrite = idEx_q.regwrite;
  assign ex_memread  = idEx_q.memread;
  assign ex_memwrite = idEx_q.memwrite;
  assign ex_memtoreg = idEx_q.memtoreg;
  assign ex_alusrc   = idEx_q.alusrc;
  assign ex_setflags = idEx_q.setflags;
  assign ex_halt     = idEx_q.halt;
  assign ex_aluop    = idEx_q.aluop;
  assign ex_rs       = idEx_q.rs;
  assign ex_rt       = idEx_q.rt;
  assign ex_rd       = idEx_q.rd;
  assign ex_a        = idEx_q.a;
  assign ex_b        = idEx_q.b;
  assign ex_imm      = idEx_q.imm;

endmodule
